scan_uart_tx: RTL

Return-path serializer for the UART-driven scan bridge. It samples TDO on each rising TCK while the bridge is in data mode (TMS=1) and packs the bits LSB-first into bytes. Completed bytes are queued in a small FIFO and transmitted as 8N1 UART frames on TX. It sits beside the RX-to-scan decoder inside `fpga_top` and drives the top-level `TX` pin.

---
 rtl/scan_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/scan_uart_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan bridge return path.
// Holds the UART TX state encoding and frame bit levels.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEF_CLKS_PER_BIT = 1250;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with show-ahead read data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_uart_tx.sv
// Packs TDO bits captured on TCK rises into bytes and sends them as 8N1 frames.
// tx is registered from the current state, so it lags the state by one clk.
module scan_uart_tx
    import scan_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdo,
    output logic tx,
    output logic busy,
    output logic overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic            tck_q;
    logic            cap;
    logic [7:0]      sr;
    logic [2:0]      bitcnt;
    logic            push;
    logic [7:0]      push_byte;
    logic            pop;
    logic [7:0]      rdata;
    logic            full;
    logic            empty;
    tx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic            baud_tc;
    logic [2:0]      idx;
    logic [7:0]      tx_byte;

    assign cap       = tck & ~tck_q;
    assign push      = cap & tms & (bitcnt == 3'd7);
    assign push_byte = {tdo, sr[7:1]};
    assign baud_tc   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_tc));
    assign busy      = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tck_q  <= 1'b0;
            sr     <= '0;
            bitcnt <= '0;
        end else begin
            tck_q <= tck;
            if (cap) begin
                if (tms) begin
                    sr     <= push_byte;
                    bitcnt <= bitcnt + 1'b1;
                end else begin
                    bitcnt <= '0;
                end
            end
        end
    end

    // Sticky: only a drop (full, no simultaneous pop) sets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_byte),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            idx      <= '0;
            tx_byte  <= '0;
            tx       <= STOP_BIT;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= STOP_BIT;
                    if (pop) begin
                        tx_byte  <= rdata;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= START_BIT;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        idx      <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= tx_byte[idx];
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= STOP_BIT;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            tx_byte <= rdata;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
